// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order imem requests,
// buffers returned words for decode, and on redirect flushes and discards stale responses.
module stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_instr_addr,
  output logic        fetch_valid
);

  localparam int              PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int              CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_qCount;
  logic [PW-1:0] r_aWr;
  logic [PW-1:0] r_aRd;
  logic [PW-1:0] r_qWr;
  logic [PW-1:0] r_qRd;
  logic [31:0]   r_aFifo  [BUF_DEPTH];
  logic [31:0]   r_qAddr  [BUF_DEPTH];
  logic [31:0]   r_qInstr [BUF_DEPTH];

  logic          w_pop;
  logic [CW:0]   w_used;
  logic          w_accept;
  logic          w_rsp;
  logic          w_drop;
  logic          w_keep;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A slot being popped this cycle is already free, so streaming keeps one word per cycle.
  always_comb begin
    w_pop    = (r_qCount != '0) && !stall;
    w_used   = {1'b0, r_inflight} + {1'b0, r_qCount} - (CW + 1)'(w_pop);
    imem_req = rst && !redirect && (w_used < DEPTH_C);
    w_accept = imem_req && imem_gnt;
    w_rsp    = imem_rvalid && (r_inflight != '0);
    w_drop   = w_rsp && (redirect || (r_discard != '0));
    w_keep   = w_rsp && !w_drop;
  end

  assign imem_addr        = r_pc;
  assign fetch_valid      = (r_qCount != '0);
  assign fetch_instr      = fetch_valid ? r_qInstr[r_qRd] : NOP;
  assign fetch_instr_addr = fetch_valid ? r_qAddr[r_qRd]  : '0;

  // Everything still outstanding at a redirect is stale and must be swallowed on return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (redirect) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= r_inflight - CW'(w_rsp);
      r_discard  <= r_inflight - CW'(w_rsp);
    end else begin
      if (w_accept) r_pc <= r_pc + 32'd4;
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_rsp);
      r_discard  <= r_discard - CW'(w_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aWr    <= '0;
      r_aRd    <= '0;
      r_qWr    <= '0;
      r_qRd    <= '0;
      r_qCount <= '0;
    end else if (redirect) begin
      r_aWr    <= '0;
      r_aRd    <= '0;
      r_qWr    <= '0;
      r_qRd    <= '0;
      r_qCount <= '0;
    end else begin
      if (w_accept) r_aWr <= nextPtr(r_aWr);
      if (w_keep) begin
        r_aRd <= nextPtr(r_aRd);
        r_qWr <= nextPtr(r_qWr);
      end
      if (w_pop) r_qRd <= nextPtr(r_qRd);
      r_qCount <= r_qCount + CW'(w_keep) - CW'(w_pop);
    end
  end

  // Storage needs no reset: contents are only observed through the counted pointers.
  always_ff @(posedge clk) begin
    if (w_accept) r_aFifo[r_aWr] <= r_pc;
    if (w_keep) begin
      r_qAddr[r_qWr]  <= r_aFifo[r_aRd];
      r_qInstr[r_qWr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: queue-based reference model checked every cycle, a 1-cycle
// instruction memory with optional hold, and directed scenarios with literal expectations.
module tb_stage_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int          DEPTH       = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_instr_addr;
  logic        fetch_valid;

  int checks   = 0;
  int failures = 0;

  logic        lastAccept = 1'b0;
  logic [31:0] lastAddr   = '0;
  logic [31:0] memQ [$];

  logic [31:0] mPc;
  logic [31:0] mInflAddr  [$];
  logic        mInflStale [$];
  logic [31:0] mQAddr     [$];
  logic [31:0] mQInstr    [$];

  always #5 clk = ~clk;

  stage_fetch #(.RESET_PC(TB_RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .fetch_instr(fetch_instr), .fetch_instr_addr(fetch_instr_addr), .fetch_valid(fetch_valid)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle with this cycle's inputs, then advanced past the coming edge.
  always @(negedge clk) begin
    logic        expValid;
    logic        expReq;
    logic        pop;
    logic [31:0] expInstr;
    logic [31:0] expAddr;
    logic [31:0] a;
    logic        s;
    int          used;
    if (!rst) begin
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      checkOutput("rst_imem_addr", imem_addr, TB_RESET_PC);
      checkOutput("rst_fetch_instr", fetch_instr, 32'h0000_0013);
      mPc = TB_RESET_PC;
      mInflAddr.delete();
      mInflStale.delete();
      mQAddr.delete();
      mQInstr.delete();
      lastAccept = 1'b0;
    end else begin
      expValid = (mQAddr.size() != 0);
      expInstr = expValid ? mQInstr[0] : 32'h0000_0013;
      expAddr  = expValid ? mQAddr[0]  : 32'h0;
      pop      = expValid && !stall;
      used     = mInflAddr.size() + mQAddr.size() - (pop ? 1 : 0);
      expReq   = !redirect && (used < DEPTH);
      checkOutput("imem_req", 32'(imem_req), 32'(expReq));
      checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("fetch_valid", 32'(fetch_valid), 32'(expValid));
      checkOutput("fetch_instr", fetch_instr, expInstr);
      checkOutput("fetch_instr_addr", fetch_instr_addr, expAddr);
      lastAccept = imem_req && imem_gnt;
      lastAddr   = imem_addr;
      if (pop) begin
        void'(mQAddr.pop_front());
        void'(mQInstr.pop_front());
      end
      if (imem_rvalid && mInflAddr.size() != 0) begin
        a = mInflAddr.pop_front();
        s = mInflStale.pop_front();
        if (!s && !redirect) begin
          mQAddr.push_back(a);
          mQInstr.push_back(imem_rdata);
        end
      end
      if (redirect) begin
        foreach (mInflStale[i]) mInflStale[i] = 1'b1;
        mQAddr.delete();
        mQInstr.delete();
        mPc = {redirect_pc[31:2], 2'b00};
      end else if (expReq && imem_gnt) begin
        mInflAddr.push_back(mPc);
        mInflStale.push_back(1'b0);
        mPc = mPc + 32'd4;
      end
    end
  end

  // One cycle of stimulus; the memory answers last cycle's accept unless held.
  task automatic applyStimulus(input logic rstIn, input logic gnt, input logic st,
                               input logic rd, input logic [31:0] rpc,
                               input logic hold, input logic spur);
    @(posedge clk);
    #2;
    if (lastAccept) memQ.push_back(lastAddr);
    rst = rstIn;
    if (!rstIn) memQ.delete();
    imem_gnt    = gnt;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (rstIn && !hold && memQ.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memQ.pop_front() | 32'h0000_0013;
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic run(input logic gnt, input logic st);
    applyStimulus(1'b1, gnt, st, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("lit_reset_req", 32'(imem_req), 32'd0);
    checkOutput("lit_reset_addr", imem_addr, 32'h0);

    // Streaming from reset
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_c0_req", 32'(imem_req), 32'd1);
    checkOutput("lit_c0_addr", imem_addr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      run(1'b1, 1'b0);
      #1;
      if (i == 1) begin
        checkOutput("lit_c1_valid", 32'(fetch_valid), 32'd0);
      end else begin
        checkOutput("lit_stream_valid", 32'(fetch_valid), 32'd1);
        checkOutput("lit_stream_addr", fetch_instr_addr, 32'((i - 2) * 4));
        checkOutput("lit_stream_instr", fetch_instr, 32'((i - 2) * 4) | 32'h13);
      end
    end

    // Stall with head at 0x8
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 1'b1);
      #1;
      checkOutput("lit_stall_head", fetch_instr_addr, 32'h8);
      checkOutput("lit_stall_req", 32'(imem_req), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 1'b0);
      #1;
      checkOutput("lit_unstall_addr", fetch_instr_addr, 32'h8 + 32'(4 * i));
    end

    // Redirect to 0x100 with two words in flight
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    #1;
    checkOutput("lit_redir_req", 32'(imem_req), 32'd0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_redir_valid0", 32'(fetch_valid), 32'd0);
    checkOutput("lit_redir_pc", imem_addr, 32'h100);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_redir_req_new", 32'(imem_req), 32'd1);
    checkOutput("lit_redir_valid1", 32'(fetch_valid), 32'd0);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_redir_first", fetch_instr_addr, 32'h100);
    checkOutput("lit_redir_first_instr", fetch_instr, 32'h113);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_redir_second", fetch_instr_addr, 32'h104);

    // Grant withheld for three cycles; stray rvalid with nothing outstanding in the last one
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, (i == 2));
      #1;
      checkOutput("lit_nogrant_addr", imem_addr, 32'h110);
    end
    checkOutput("lit_nogrant_drained", 32'(fetch_valid), 32'd0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_spurious_ignored", 32'(fetch_valid), 32'd0);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_resume_first", fetch_instr_addr, 32'h110);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_resume_second", fetch_instr_addr, 32'h114);

    // Reset mid-stream
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("lit_midrst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("lit_midrst_req", 32'(imem_req), 32'd0);
    checkOutput("lit_midrst_addr", imem_addr, TB_RESET_PC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_release_addr", imem_addr, TB_RESET_PC);
    checkOutput("lit_release_req", 32'(imem_req), 32'd1);
    run(1'b1, 1'b0);

    // Redirect colliding with a response and a stall
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 1'b0);
    #1;
    checkOutput("lit_collide_rvalid", 32'(imem_rvalid), 32'd1);
    checkOutput("lit_collide_req", 32'(imem_req), 32'd0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_collide_empty", 32'(fetch_valid), 32'd0);
    checkOutput("lit_collide_pc", imem_addr, 32'h200);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    #1;
    checkOutput("lit_collide_first", fetch_instr_addr, 32'h200);
    checkOutput("lit_collide_instr", fetch_instr, 32'h213);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
